tlb_op_ctrl: RTL and testbench
==============================

# tlb_op_ctrl

Sequencer for CP0 TLB instructions (TLBP, TLBR, TLBWI, TLBWR). It sits between the CP0/MEM stage and the MMU's TLBR/TLBWI/TLBWR and TLBP ports. It snapshots operands and drives the MMU for one execute cycle, then returns results to CP0 with a done pulse. It also owns the Random register, holding the pipeline busy for the duration.

## Interface
Parameters:
- TLB_ENTRIES, 16, number of TLB entries, power of two; IW = $clog2(TLB_ENTRIES)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  committed TLB instruction present
- op_type  in  2  0=TLBP, 1=TLBR, 2=TLBWI, 3=TLBWR
- op_ready  out  1  controller can accept; high only in IDLE
- op_done  out  1  one-cycle pulse; results valid
- flush_pipe  out  1  one-cycle pulse with op_done for TLBR/TLBWI/TLBWR (ASID/mapping change)
- cp0_entry_hi, cp0_index  in  32  current CP0 values
- cp0_entry  in  tlb_entry_t  entry assembled from EntryHi/Lo0/Lo1/PageMask
- cp0_wired  in  IW  Wired register
- cp0_wired_we  in  1  MTC0 to Wired this cycle
- random  out  IW  Random register for MFC0
- tlbrw_index  out  tlb_index_t  to MMU
- tlbrw_we  out  1  to MMU
- tlbrw_wdata  out  tlb_entry_t  to MMU
- tlbrw_rdata  in  tlb_entry_t  from MMU
- tlbp_entry_hi  out  32  to MMU
- tlbp_index  in  32  from MMU, bit 31 = P (miss)
- index_we, index_wdata  out  1, 32  CP0 Index update (TLBP)
- entry_we, entry_wdata  out  1, tlb_entry_t  CP0 EntryHi/Lo/PageMask update (TLBR)

## Operation
- FSM states: IDLE, PROBE, READ, WRITE, DONE.
- IDLE: op_ready=1. On op_valid, latch op_type, cp0_entry_hi, cp0_entry, and the index. The index is cp0_index[IW-1:0], or random for TLBWR. Then go to PROBE, READ, or WRITE.
- PROBE: drive tlbp_entry_hi = latched EntryHi. Capture tlbp_index at clock edge. Go to DONE.
- READ: drive tlbrw_index = latched index. Capture tlbrw_rdata. Go to DONE.
- WRITE: tlbrw_we=1 for exactly this cycle, with latched index and tlbrw_wdata = latched entry. Go to DONE.
- DONE: op_done=1.
  - TLBP: index_we=1, index_wdata = captured tlbp_index.
  - TLBR: entry_we=1, entry_wdata = captured rdata.
  - flush_pipe=1 unless TLBP.
  - Go to IDLE.
- Outside their states, tlbrw_we, index_we, entry_we, op_done, and flush_pipe are 0. tlbrw_index, tlbp_entry_hi, and tlbrw_wdata always reflect latched values.
- CP0 changes after accept do not affect the in-flight operation (snapshot rule).
- Random, updated every cycle:
  - if cp0_wired_we: TLB_ENTRIES-1
  - else if random == cp0_wired or random == 0: TLB_ENTRIES-1
  - else: random-1
  - If cp0_wired >= TLB_ENTRIES-1, random holds TLB_ENTRIES-1.
  - TLBWR uses the random value sampled in the accept cycle.
- op_valid while not IDLE is ignored. The upstream stage holds the instruction until op_ready && op_valid.

## Timing
- Accept at cycle T. MMU access at T+1. op_done and CP0 writes at T+2. Next accept is possible at T+3.
- tlbrw_we asserts at T+1 only. The MMU write lands at the end of T+1, so a TLBR accepted at T+3 sees it.
- Reset values:
  - state IDLE, op_ready 1
  - random TLB_ENTRIES-1
  - all latches 0
  - tlbrw_we, op_done, flush_pipe, index_we, entry_we 0
- Reset asserted mid-operation: FSM goes to IDLE asynchronously and tlbrw_we drops immediately. No op_done is produced.
- cp0_wired_we in the same cycle as a TLBWR accept: the TLBWR uses the pre-update random; random reloads afterwards.

## Structure
- Shared package (cpu_defs):
  - op encoding typedef tlb_op_t
  - state enum
  - reuse of the existing tlb_entry_t and tlb_index_t typedefs
- Natural sub-module: tlb_random_reg, holding the Random counter with its Wired/reload logic.
- The FSM stays in tlb_op_ctrl.

## Test plan
- Reset: release reset → random=15, op_ready=1, all strobes 0. Then Wired=0 with no writes → random counts 15,14,…,0,15.
- Wired=4: cp0_wired_we pulse → random=15 the next cycle, then counts down to 4 and wraps to 15. Random never goes below 4.
- TLBP hit then miss:
  - Entry 5 holds VPN2 0x00400; probe EntryHi 0x00400_0xx → at T+2 index_we=1, index_wdata=5.
  - Probe an unmapped VPN → index_wdata[31]=1.
  - flush_pipe=0 in both cases.
- TLBWI then TLBR:
  - Index=3, write an entry → tlbrw_we high only at T+1 with index 3.
  - A following TLBR of index 3 → entry_wdata equals the written entry; flush_pipe pulses both times.
- TLBWR snapshot: accept with random=9 while cp0_index=2 → write goes to index 9. Changing cp0_entry during WRITE does not alter tlbrw_wdata.
- Reset mid-WRITE: assert reset during WRITE → tlbrw_we=0 immediately, no op_done, op_ready=1 after release.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: TLB entry/index types, TLB op encoding and
// the TLB op sequencer state encoding.
package cpu_defs;

    localparam int TLB_NUM = 16;
    localparam int TLB_IW  = $clog2(TLB_NUM);

    typedef logic [TLB_IW-1:0] tlb_index_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
        logic [15:0] mask;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        OP_TLBP  = 2'd0,
        OP_TLBR  = 2'd1,
        OP_TLBWI = 2'd2,
        OP_TLBWR = 2'd3
    } tlb_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROBE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } tlb_state_t;

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// TLB op handshake between the CP0/MEM stage (master) and the sequencer
// (slave): op_valid/op_type in, op_ready/op_done/flush_pipe back.
interface tlb_op_ctrl_if;
    import cpu_defs::*;

    logic    op_valid;
    tlb_op_t op_type;
    logic    op_ready;
    logic    op_done;
    logic    flush_pipe;

    modport master (
        output op_valid, op_type,
        input  op_ready, op_done, flush_pipe
    );

    modport slave (
        input  op_valid, op_type,
        output op_ready, op_done, flush_pipe
    );

endinterface

// File: rtl/tlb_random_reg.sv
// CP0 Random counter: counts down each cycle from TLB_ENTRIES-1 to Wired,
// reloads on a Wired write. Ports: clk, reset, wired, wired_we, random.
module tlb_random_reg #(
    parameter  int TLB_ENTRIES = 16,
    localparam int IW          = $clog2(TLB_ENTRIES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] wired,
    input  logic          wired_we,
    output logic [IW-1:0] random
);

    localparam logic [IW-1:0] MAX = IW'(TLB_ENTRIES - 1);

    // Wired at the top entry leaves no random range: pin to MAX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            random <= MAX;
        end else if (wired_we || wired >= MAX ||
                     random == wired || random == '0) begin
            random <= MAX;
        end else begin
            random <= random - 1'b1;
        end
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBP/TLBR/TLBWI/TLBWR: snapshots CP0 operands, drives the
// MMU for one cycle, returns results to CP0 with op_done; owns Random.
// Ports: clk, reset, op (handshake if), cp0_* inputs, random, tlbrw_*,
// tlbp_*, index_we/index_wdata, entry_we/entry_wdata.
module tlb_op_ctrl
    import cpu_defs::*;
#(
    parameter  int TLB_ENTRIES = TLB_NUM,
    localparam int IW          = $clog2(TLB_ENTRIES)
) (
    input  logic          clk,
    input  logic          reset,
    tlb_op_ctrl_if.slave  op,
    input  logic [31:0]   cp0_entry_hi,
    input  logic [31:0]   cp0_index,
    input  tlb_entry_t    cp0_entry,
    input  logic [IW-1:0] cp0_wired,
    input  logic          cp0_wired_we,
    output logic [IW-1:0] random,
    output tlb_index_t    tlbrw_index,
    output logic          tlbrw_we,
    output tlb_entry_t    tlbrw_wdata,
    input  tlb_entry_t    tlbrw_rdata,
    output logic [31:0]   tlbp_entry_hi,
    input  logic [31:0]   tlbp_index,
    output logic          index_we,
    output logic [31:0]   index_wdata,
    output logic          entry_we,
    output tlb_entry_t    entry_wdata
);

    tlb_state_t    state, state_nx;
    tlb_op_t       op_q;
    logic [31:0]   ehi_q;
    tlb_entry_t    entry_q;
    logic [IW-1:0] idx_q;
    logic [31:0]   pidx_q;
    tlb_entry_t    rdata_q;
    logic          accept;
    logic          unused_idx;

    assign unused_idx = ^cp0_index[31:IW];

    tlb_random_reg #(
        .TLB_ENTRIES (TLB_ENTRIES)
    ) u_random (
        .clk      (clk),
        .reset    (reset),
        .wired    (cp0_wired),
        .wired_we (cp0_wired_we),
        .random   (random)
    );

    assign accept = (state == ST_IDLE) && op.op_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            op_q    <= OP_TLBP;
            ehi_q   <= '0;
            entry_q <= '0;
            idx_q   <= '0;
            pidx_q  <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q    <= op.op_type;
                ehi_q   <= cp0_entry_hi;
                entry_q <= cp0_entry;
                // TLBWR takes Random as it stands in the accept cycle.
                idx_q   <= (op.op_type == OP_TLBWR) ?
                           random : cp0_index[IW-1:0];
            end
            if (state == ST_PROBE) begin
                pidx_q <= tlbp_index;
            end
            if (state == ST_READ) begin
                rdata_q <= tlbrw_rdata;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        op.op_ready   = 1'b0;
        op.op_done    = 1'b0;
        op.flush_pipe = 1'b0;
        tlbrw_we      = 1'b0;
        index_we      = 1'b0;
        entry_we      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                op.op_ready = 1'b1;
                if (op.op_valid) begin
                    unique case (op.op_type)
                        OP_TLBP:  state_nx = ST_PROBE;
                        OP_TLBR:  state_nx = ST_READ;
                        OP_TLBWI: state_nx = ST_WRITE;
                        OP_TLBWR: state_nx = ST_WRITE;
                        default:  state_nx = ST_IDLE;
                    endcase
                end
            end
            ST_PROBE: state_nx = ST_DONE;
            ST_READ:  state_nx = ST_DONE;
            ST_WRITE: begin
                tlbrw_we = 1'b1;
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                op.op_done    = 1'b1;
                index_we      = (op_q == OP_TLBP);
                entry_we      = (op_q == OP_TLBR);
                // Any non-probe op may change ASID or mappings.
                op.flush_pipe = (op_q != OP_TLBP);
                state_nx      = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign tlbrw_index   = tlb_index_t'(idx_q);
    assign tlbrw_wdata   = entry_q;
    assign tlbp_entry_hi = ehi_q;
    assign index_wdata   = pidx_q;
    assign entry_wdata   = rdata_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Randomized self-checking bench for tlb_op_ctrl with an MMU stub and a
// transaction-level reference model of the TLB array and Random.
module tb_tlb_op_ctrl;
    import cpu_defs::*;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cp0_entry_hi = '0;
    logic [31:0] cp0_index = '0;
    tlb_entry_t  cp0_entry = '0;
    logic [3:0]  cp0_wired = '0;
    logic        cp0_wired_we = 1'b0;
    logic [3:0]  random;
    tlb_index_t  tlbrw_index;
    logic        tlbrw_we;
    tlb_entry_t  tlbrw_wdata;
    tlb_entry_t  tlbrw_rdata;
    logic [31:0] tlbp_entry_hi;
    logic [31:0] tlbp_index;
    logic        index_we;
    logic [31:0] index_wdata;
    logic        entry_we;
    tlb_entry_t  entry_wdata;

    int n_chk = 0;
    int n_fail = 0;
    bit rchk_en = 1'b0;

    tlb_op_ctrl_if opif ();

    tlb_op_ctrl #(.TLB_ENTRIES(N)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .op            (opif),
        .cp0_entry_hi  (cp0_entry_hi),
        .cp0_index     (cp0_index),
        .cp0_entry     (cp0_entry),
        .cp0_wired     (cp0_wired),
        .cp0_wired_we  (cp0_wired_we),
        .random        (random),
        .tlbrw_index   (tlbrw_index),
        .tlbrw_we      (tlbrw_we),
        .tlbrw_wdata   (tlbrw_wdata),
        .tlbrw_rdata   (tlbrw_rdata),
        .tlbp_entry_hi (tlbp_entry_hi),
        .tlbp_index    (tlbp_index),
        .index_we      (index_we),
        .index_wdata   (index_wdata),
        .entry_we      (entry_we),
        .entry_wdata   (entry_wdata)
    );

    always #5 clk = ~clk;

    // MMU stub
    tlb_entry_t mmu [N] = '{default: '0};

    assign tlbrw_rdata = mmu[tlbrw_index];

    always_comb begin
        tlbp_index = 32'h8000_0000;
        for (int i = N - 1; i >= 0; i--) begin
            if (mmu[i].vpn2 == tlbp_entry_hi[31:13]) tlbp_index = i;
        end
    end

    always @(posedge clk) begin
        if (tlbrw_we) mmu[tlbrw_index] <= tlbrw_wdata;
    end

    // Reference model
    tlb_entry_t ref_tlb [N] = '{default: '0};
    logic [3:0] exp_rand;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            exp_rand <= 4'd15;
        else if (cp0_wired_we || cp0_wired == 4'd15 || exp_rand <= cp0_wired)
            exp_rand <= 4'd15;
        else
            exp_rand <= exp_rand - 4'd1;
    end

    function automatic logic [31:0] ref_probe(input logic [18:0] v);
        for (int i = 0; i < N; i++) begin
            if (ref_tlb[i].vpn2 == v) return 32'(i);
        end
        return 32'h8000_0000;
    endfunction

    function automatic tlb_entry_t rand_entry();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[$bits(tlb_entry_t)-1:0];
    endfunction

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rchk_en) check("random", 128'(random), 128'(exp_rand));
    end

    // Called at a negedge; returns at the negedge of T+3.
    task automatic do_op(input tlb_op_t op, input logic [31:0] idx,
                         input logic [31:0] ehi, input tlb_entry_t ent,
                         input bit wwe, input logic [3:0] wval,
                         input bit noise);
        logic [3:0]  eidx;
        logic [31:0] exp_p;
        tlb_entry_t  exp_r;
        bit          is_wr;
        is_wr = (op == OP_TLBWI) || (op == OP_TLBWR);
        check("ready_in", 128'(opif.op_ready), 128'(1));
        opif.op_valid = 1'b1;
        opif.op_type  = op;
        cp0_index     = idx;
        cp0_entry_hi  = ehi;
        cp0_entry     = ent;
        cp0_wired_we  = wwe;
        if (wwe) cp0_wired = wval;
        eidx  = (op == OP_TLBWR) ? exp_rand : idx[3:0];
        exp_p = ref_probe(ehi[31:13]);
        exp_r = ref_tlb[eidx];
        @(posedge clk);
        @(negedge clk);
        cp0_wired_we  = 1'b0;
        opif.op_valid = noise;
        opif.op_type  = tlb_op_t'($urandom_range(0, 3));
        cp0_entry     = rand_entry();
        cp0_entry_hi  = $urandom();
        cp0_index     = $urandom();
        check("ready_busy", 128'(opif.op_ready), 128'(0));
        check("done_t1", 128'(opif.op_done), 128'(0));
        check("we_t1", 128'(tlbrw_we), 128'(is_wr));
        if (is_wr) begin
            check("wr_idx", 128'(tlbrw_index), 128'(eidx));
            check("wr_data", 128'(tlbrw_wdata), 128'(ent));
            ref_tlb[eidx] = ent;
        end
        if (op == OP_TLBR) check("rd_idx", 128'(tlbrw_index), 128'(eidx));
        if (op == OP_TLBP) check("p_ehi", 128'(tlbp_entry_hi), 128'(ehi));
        @(posedge clk);
        @(negedge clk);
        check("done", 128'(opif.op_done), 128'(1));
        check("flush", 128'(opif.flush_pipe), 128'(op != OP_TLBP));
        check("index_we", 128'(index_we), 128'(op == OP_TLBP));
        check("entry_we", 128'(entry_we), 128'(op == OP_TLBR));
        check("we_t2", 128'(tlbrw_we), 128'(0));
        if (op == OP_TLBP)
            check("index_wdata", 128'(index_wdata), 128'(exp_p));
        if (op == OP_TLBR)
            check("entry_wdata", 128'(entry_wdata), 128'(exp_r));
        opif.op_valid = noise;
        cp0_entry     = rand_entry();
        @(posedge clk);
        @(negedge clk);
        opif.op_valid = 1'b0;
        check("ready_t3", 128'(opif.op_ready), 128'(1));
        check("done_t3", 128'(opif.op_done), 128'(0));
        check("flush_t3", 128'(opif.flush_pipe), 128'(0));
    endtask

    tlb_op_t     rop;
    tlb_entry_t  ent;
    logic [31:0] ehi;
    bit          hit_wait;

    initial begin
        opif.op_valid = 1'b0;
        opif.op_type  = OP_TLBP;
        repeat (3) @(negedge clk);
        check("rst_ready", 128'(opif.op_ready), 128'(1));
        check("rst_random", 128'(random), 128'(15));
        check("rst_we", 128'(tlbrw_we), 128'(0));
        check("rst_done", 128'(opif.op_done), 128'(0));
        check("rst_flush", 128'(opif.flush_pipe), 128'(0));
        check("rst_iwe", 128'(index_we), 128'(0));
        check("rst_ewe", 128'(entry_we), 128'(0));
        check("rst_idx", 128'(tlbrw_index), 128'(0));
        check("rst_wdata", 128'(tlbrw_wdata), 128'(0));
        rst_n   = 1'b1;
        rchk_en = 1'b1;

        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("rand_seq", 128'(random), 128'((31 - k) % 16));
        end

        cp0_wired    = 4'd4;
        cp0_wired_we = 1'b1;
        @(negedge clk);
        cp0_wired_we = 1'b0;
        check("wired_reload", 128'(random), 128'(15));
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("rand_w4", 128'(random), 128'((k == 12) ? 15 : 15 - k));
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("rand_floor", 128'(random >= 4'd4), 128'(1));
        end

        ent      = rand_entry();
        ent.vpn2 = 19'h00400;
        do_op(OP_TLBWI, 32'd5, $urandom(), ent, 0, 0, 0);
        do_op(OP_TLBP, 32'd0, {19'h00400, 13'h0a5}, rand_entry(), 0, 0, 1);
        check("probe_hit", 128'(index_wdata), 128'(5));
        do_op(OP_TLBP, 32'd0, {19'h7abcd, 13'h011}, rand_entry(), 0, 0, 0);
        check("probe_miss", 128'(index_wdata[31]), 128'(1));

        ent = rand_entry();
        do_op(OP_TLBWI, 32'd3, $urandom(), ent, 0, 0, 0);
        do_op(OP_TLBR, 32'd3, $urandom(), rand_entry(), 0, 0, 0);
        check("tlbr_back", 128'(entry_wdata), 128'(ent));

        hit_wait = 1'b0;
        for (int k = 0; k < 40 && !hit_wait; k++) begin
            @(negedge clk);
            if (exp_rand == 4'd9) hit_wait = 1'b1;
        end
        check("wait_rand9", 128'(hit_wait), 128'(1));
        ent = rand_entry();
        do_op(OP_TLBWR, 32'd2, $urandom(), ent, 0, 0, 1);
        check("tlbwr_9", 128'(ref_tlb[9]), 128'(ent));
        check("tlbwr_idx2", 128'(mmu[2] == ent), 128'(0));

        // Reset mid-WRITE
        opif.op_valid = 1'b1;
        opif.op_type  = OP_TLBWI;
        cp0_index     = 32'd7;
        cp0_entry     = rand_entry();
        @(posedge clk);
        @(negedge clk);
        opif.op_valid = 1'b0;
        check("mid_we", 128'(tlbrw_we), 128'(1));
        #1 rst_n = 1'b0;
        #1;
        check("mid_we_drop", 128'(tlbrw_we), 128'(0));
        check("mid_ready", 128'(opif.op_ready), 128'(1));
        check("mid_done", 128'(opif.op_done), 128'(0));
        check("mid_random", 128'(random), 128'(15));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_done", 128'(opif.op_done), 128'(0));
            check("post_ready", 128'(opif.op_ready), 128'(1));
            check("post_we", 128'(tlbrw_we), 128'(0));
        end
        do_op(OP_TLBR, 32'd7, $urandom(), rand_entry(), 0, 0, 0);

        for (int k = 0; k < 60; k++) begin
            rop = tlb_op_t'($urandom_range(0, 3));
            ehi = $urandom();
            if ($urandom_range(0, 1) == 0)
                ehi[31:13] = ref_tlb[$urandom_range(0, N - 1)].vpn2;
            do_op(rop, $urandom(), ehi, rand_entry(),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0) ? 4'd15 :
                                                4'($urandom_range(0, 15)),
                  $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        rchk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
